// File: rtl/logger_pkg.sv
// Shared types and widths for the logger acquisition core.
package logger_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    RELAY_ON,
    WAIT_DRDY,
    READ,
    STORE,
    RELAY_OFF,
    DONE
  } state_t;

  // Word index must be able to hold N_SAMPLES itself, hence the extra bit.
  function automatic int idx_w(input int n_samples);
    return $clog2(n_samples) + 1;
  endfunction

endpackage

// File: rtl/adc_serial_rx.sv
// Bit-banged 16-bit serial ADC reader: SCLK idles low, SDIN sampled on the last cycle of each high phase.
// Latency: done strobes 32*SCLK_HALF+1 cycles after start; start is ignored while busy, no backpressure.
module adc_serial_rx
  import logger_pkg::*;
#(
  parameter int SCLK_HALF = 4
) (
  input  logic              clk,
  input  logic              res,
  input  logic              start,
  input  logic              sdin,
  output logic              sclk,
  output logic [WORD_W-1:0] word,
  output logic              done
);

  localparam int PW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

  logic          busy;
  logic [PW-1:0] ph_cnt;
  logic [3:0]    bit_cnt;
  logic          ph_end;

  assign ph_end = (ph_cnt == PW'(SCLK_HALF - 1));

  always_ff @(posedge clk) begin
    if (res) begin
      busy    <= 1'b0;
      sclk    <= 1'b0;
      ph_cnt  <= '0;
      bit_cnt <= '0;
      word    <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          busy    <= 1'b1;
          ph_cnt  <= '0;
          bit_cnt <= '0;
        end
      end else if (!ph_end) begin
        ph_cnt <= ph_cnt + 1'b1;
      end else begin
        ph_cnt <= '0;
        if (!sclk) begin
          sclk <= 1'b1;
        end else begin
          // end of high phase: capture the bit and drop the clock
          sclk    <= 1'b0;
          word    <= {word[WORD_W-2:0], sdin};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == 4'd15) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/logger_acq_core.sv
// Data-logger acquisition: relay pulse, N_SAMPLES serial ADC words, pulse_in counting, MCU SPI readback.
// Latency: a run spans 2*RELAY_CYC cycles plus N_SAMPLES nDRDY periods; no backpressure, SPI port is read-only.
module logger_acq_core
  import logger_pkg::*;
#(
  parameter int N_SAMPLES  = 8,
  parameter int SCLK_HALF  = 4,
  parameter int CLKOUT_DIV = 2,
  parameter int RELAY_CYC  = 250
) (
  input  logic       clk,
  input  logic       res,
  input  logic       start_pulse,
  output logic       data_done,
  input  logic       pulse_in,
  output logic       relayAp,
  output logic       relayAn,
  output logic       relayBp,
  output logic       relayBn,
  output logic       Clk_Out,
  input  logic       SDOUTu,
  input  logic       SCLKu,
  input  logic       CSu,
  output logic       SDINu,
  input  logic       nDRDY,
  input  logic       SDIN1,
  output logic       SCLK1,
  input  logic       SDOUTe,
  output logic       SDINe,
  output logic       SCLKe,
  output logic [3:0] CSe
);

  localparam int IW          = idx_w(N_SAMPLES);
  localparam int BW          = $clog2(N_SAMPLES);
  localparam int RW          = $clog2(RELAY_CYC);
  localparam int CW          = (CLKOUT_DIV > 1) ? $clog2(CLKOUT_DIV) : 1;
  localparam int STREAM_BITS = WORD_W * (N_SAMPLES + 1);
  localparam int PW          = $clog2(STREAM_BITS);
  // sync bit order: {start, SDIN1, pulse_in, nDRDY, SCLKu, CSu}; CSu idles high
  localparam logic [5:0] SYNC_RST = 6'b000001;

  logic unused_inputs;
  assign unused_inputs = ^{SDOUTu, SDOUTe};

  assign CSe   = 4'hF;
  assign SCLKe = 1'b0;
  assign SDINe = 1'b0;

  logic [5:0] sync1, sync2;
  logic [3:0] sync3;

  always_ff @(posedge clk) begin
    if (res) begin
      sync1 <= SYNC_RST;
      sync2 <= SYNC_RST;
      sync3 <= SYNC_RST[3:0];
    end else begin
      sync1 <= {start_pulse, SDIN1, pulse_in, nDRDY, SCLKu, CSu};
      sync2 <= sync1;
      sync3 <= sync2[3:0];
    end
  end

  logic cs_low, cs_fall, sclku_fall, drdy_rise, pulse_rise, sdin_s, start_s;
  assign cs_low     = ~sync2[0];
  assign cs_fall    = ~sync2[0] &  sync3[0];
  assign sclku_fall = ~sync2[1] &  sync3[1];
  assign drdy_rise  =  sync2[2] & ~sync3[2];
  assign pulse_rise =  sync2[3] & ~sync3[3];
  assign sdin_s     =  sync2[4];
  assign start_s    =  sync2[5];

  state_t            state, state_nxt;
  logic [RW-1:0]     relay_cnt;
  logic              relay_last;
  logic              rx_start, rx_done;
  logic [WORD_W-1:0] rx_word;
  logic [IW-1:0]     idx;
  logic [WORD_W-1:0] pulse_cnt;
  logic [WORD_W-1:0] buffer [N_SAMPLES];

  assign relay_last = (relay_cnt == RW'(RELAY_CYC - 1));

  always_ff @(posedge clk) begin
    if (res) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rx_start  = 1'b0;
    unique case (state)
      IDLE:      if (start_s) state_nxt = RELAY_ON;
      RELAY_ON:  if (relay_last) state_nxt = WAIT_DRDY;
      WAIT_DRDY: if (drdy_rise) begin
                   state_nxt = READ;
                   rx_start  = 1'b1;
                 end
      READ:      if (rx_done) state_nxt = STORE;
      STORE:     state_nxt = (idx == IW'(N_SAMPLES - 1)) ? RELAY_OFF : WAIT_DRDY;
      RELAY_OFF: if (relay_last) state_nxt = DONE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Coil drives decode directly from the state, so p/n of a pair can never overlap.
  assign relayAp   = (state == RELAY_ON);
  assign relayBp   = (state == RELAY_ON);
  assign relayAn   = (state == RELAY_OFF);
  assign relayBn   = (state == RELAY_OFF);
  assign data_done = (state == DONE);

  always_ff @(posedge clk) begin
    if (res)
      relay_cnt <= '0;
    else if ((state == RELAY_ON || state == RELAY_OFF) && !relay_last)
      relay_cnt <= relay_cnt + 1'b1;
    else
      relay_cnt <= '0;
  end

  adc_serial_rx #(.SCLK_HALF(SCLK_HALF)) u_adc_rx (
    .clk   (clk),
    .res   (res),
    .start (rx_start),
    .sdin  (sdin_s),
    .sclk  (SCLK1),
    .word  (rx_word),
    .done  (rx_done)
  );

  always_ff @(posedge clk) begin
    if (res) begin
      idx       <= '0;
      pulse_cnt <= '0;
    end else if (state == IDLE && start_s) begin
      idx       <= '0;
      pulse_cnt <= '0;
    end else begin
      if ((state == WAIT_DRDY || state == READ || state == STORE) &&
          pulse_rise && pulse_cnt != 16'hFFFF)
        pulse_cnt <= pulse_cnt + 1'b1;
      if (state == STORE)
        idx <= idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      for (int i = 0; i < N_SAMPLES; i++) buffer[i] <= '0;
    end else if (state == STORE) begin
      buffer[idx[BW-1:0]] <= rx_word;
    end
  end

  // MCU stream: word 0 is the pulse count, words 1..N are the buffer; wraps at the end.
  logic [PW-1:0]     bit_ptr, ptr_nxt;
  logic [PW-5:0]     word_sel;
  logic [WORD_W-1:0] stream_word;

  always_comb begin
    ptr_nxt = '0;
    if (!cs_fall && bit_ptr != PW'(STREAM_BITS - 1))
      ptr_nxt = bit_ptr + 1'b1;
    word_sel    = ptr_nxt[PW-1:4];
    stream_word = pulse_cnt;
    if (word_sel != '0)
      stream_word = buffer[BW'(word_sel - 1'b1)];
  end

  always_ff @(posedge clk) begin
    if (res) begin
      bit_ptr <= '0;
      SDINu   <= 1'b0;
    end else if (cs_fall || (sclku_fall && cs_low)) begin
      bit_ptr <= ptr_nxt;
      SDINu   <= stream_word[~ptr_nxt[3:0]];
    end else if (!cs_low) begin
      SDINu <= 1'b0;
    end
  end

  logic [CW-1:0] div_cnt;

  always_ff @(posedge clk) begin
    if (res) begin
      div_cnt <= '0;
      Clk_Out <= 1'b0;
    end else if (div_cnt == CW'(CLKOUT_DIV - 1)) begin
      div_cnt <= '0;
      Clk_Out <= ~Clk_Out;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_logger_acq_core.sv
// Scoreboard bench for logger_acq_core: directed runs, ADC model, MCU readout, mid-run reset.
module tb_logger_acq_core;

  logic clk;
  logic res, start_pulse, pulse_in, SDOUTu, SCLKu, CSu, SDOUTe;
  logic nDRDY = 1'b0;
  logic SDIN1 = 1'b0;
  logic data_done, relayAp, relayAn, relayBp, relayBn, Clk_Out, SDINu, SCLK1, SDINe, SCLKe;
  logic [3:0] CSe;

  logger_acq_core dut (
    .clk(clk), .res(res), .start_pulse(start_pulse), .data_done(data_done),
    .pulse_in(pulse_in), .relayAp(relayAp), .relayAn(relayAn), .relayBp(relayBp),
    .relayBn(relayBn), .Clk_Out(Clk_Out), .SDOUTu(SDOUTu), .SCLKu(SCLKu), .CSu(CSu),
    .SDINu(SDINu), .nDRDY(nDRDY), .SDIN1(SDIN1), .SCLK1(SCLK1), .SDOUTe(SDOUTe),
    .SDINe(SDINe), .SCLKe(SCLKe), .CSe(CSe)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  localparam int K_RELAY_P = 0, K_RELAY_N = 1, K_DONE = 2, K_WORD = 3, K_TAIL = 4;

  typedef struct {
    int          kind;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic string kname(input int k);
    case (k)
      K_RELAY_P: return "relay_p_width";
      K_RELAY_N: return "relay_n_width";
      K_DONE:    return "done_width";
      K_WORD:    return "spi_word";
      default:   return "spi_tail";
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void push(input int k, input logic [31:0] v);
    exp_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endfunction

  task automatic emit(input int k, input logic [31:0] v);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_%s actual=%0h required=none", kname(k), v);
    end else begin
      e = exp_q.pop_front();
      check(kname(e.kind), {32'(k), v}, {32'(e.kind), e.val});
    end
  endtask

  // Monitor: turns DUT output activity into observations and scores them in order.
  initial begin
    int p_len = 0, n_len = 0, d_len = 0, spi_n = 0;
    bit p_bad = 0, n_bad = 0;
    logic sclku_q = 1'b0, csu_q = 1'b1;
    logic [15:0] spi_sh = '0;
    forever begin
      @(posedge clk);
      #1;
      if (relayAp || relayBp) begin
        p_len++;
        if (!(relayAp && relayBp) || relayAn || relayBn) p_bad = 1;
      end else if (p_len > 0) begin
        emit(K_RELAY_P, p_bad ? 32'hBAD : 32'(p_len));
        p_len = 0; p_bad = 0;
      end
      if (relayAn || relayBn) begin
        n_len++;
        if (!(relayAn && relayBn) || relayAp || relayBp) n_bad = 1;
      end else if (n_len > 0) begin
        emit(K_RELAY_N, n_bad ? 32'hBAD : 32'(n_len));
        n_len = 0; n_bad = 0;
      end
      if (data_done) d_len++;
      else if (d_len > 0) begin
        emit(K_DONE, 32'(d_len));
        d_len = 0;
      end
      if (!CSu && SCLKu && !sclku_q) begin
        spi_sh = {spi_sh[14:0], SDINu};
        spi_n++;
        if (spi_n == 16) begin
          emit(K_WORD, {16'h0, spi_sh});
          spi_n = 0; spi_sh = '0;
        end
      end
      if (CSu && !csu_q && spi_n > 0) begin
        emit(K_TAIL, {spi_n[15:0], spi_sh});
        spi_n = 0; spi_sh = '0;
      end
      sclku_q = SCLKu;
      csu_q   = CSu;
    end
  end

  // ADC model: nDRDY ~250 ns high every 781 clk (31.25 us); counter loaded on the rise, shifted on SCLK1 falls.
  logic adc_en = 1'b0;
  initial begin
    int adc_tick = 0, drdy_hold = 0;
    logic [15:0] adc_cnt = '0, adc_sh = '0;
    logic sclk_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!adc_en) begin
        adc_tick = 0; drdy_hold = 0; adc_cnt = '0; adc_sh = '0;
        nDRDY = 1'b0;
      end else begin
        adc_tick++;
        if (adc_tick == 781) begin
          adc_tick = 0; nDRDY = 1'b1; drdy_hold = 6;
          adc_sh = adc_cnt; adc_cnt++;
        end else if (drdy_hold > 0) begin
          drdy_hold--;
          if (drdy_hold == 0) nDRDY = 1'b0;
        end
        if (sclk_prev && !SCLK1) adc_sh = {adc_sh[14:0], 1'b0};
      end
      sclk_prev = SCLK1;
      SDIN1 = adc_sh[15];
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic event_pulse();
    pulse_in = 1'b1; cycles(5);
    pulse_in = 1'b0; cycles(10);
  endtask

  task automatic start_run();
    push(K_RELAY_P, 250);
    push(K_RELAY_N, 250);
    push(K_DONE, 1);
    adc_en = 1'b1;
    start_pulse = 1'b1; cycles(3);
    start_pulse = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 9000; i++) begin
      @(negedge clk);
      if (data_done) break;
    end
    check(name, 64'(data_done), 64'd1);
    cycles(5);
    adc_en = 1'b0;
  endtask

  task automatic mcu_read(input int nclk);
    CSu = 1'b0; cycles(12);
    for (int i = 0; i < nclk; i++) begin
      SCLKu = 1'b1; cycles(12);
      SCLKu = 1'b0; cycles(13);
    end
    CSu = 1'b1; cycles(6);
  endtask

  initial begin
    int toggles;
    logic prev_clk_out;
    res = 1'b1; start_pulse = 1'b0; pulse_in = 1'b0;
    SDOUTu = 1'b0; SCLKu = 1'b0; CSu = 1'b1; SDOUTe = 1'b0;
    cycles(3);

    check("rst_cse", 64'(CSe), 64'hF);
    check("rst_relays", 64'({relayAp, relayAn, relayBp, relayBn}), 64'h0);
    check("rst_sclk1", 64'(SCLK1), 64'h0);
    check("rst_data_done", 64'(data_done), 64'h0);
    check("rst_sdinu", 64'(SDINu), 64'h0);
    check("rst_eeprom_lines", 64'({SCLKe, SDINe}), 64'h0);
    check("rst_clk_out", 64'(Clk_Out), 64'h0);
    res = 1'b0;

    toggles = 0;
    prev_clk_out = Clk_Out;
    for (int i = 0; i < 16; i++) begin
      cycles(1);
      if (Clk_Out !== prev_clk_out) toggles++;
      prev_clk_out = Clk_Out;
    end
    check("clk_out_toggles_16cyc", 64'(toggles), 64'd8);

    // Run 1: five events in the run, a stray start mid-run, three events while idle.
    start_run();
    cycles(300);
    repeat (5) event_pulse();
    start_pulse = 1'b1; cycles(2); start_pulse = 1'b0;
    wait_done("run1_done_seen");
    repeat (3) event_pulse();

    push(K_WORD, 5);
    for (int i = 0; i < 8; i++) push(K_WORD, 32'(i));
    push(K_TAIL, {16'd1, 16'd0});
    mcu_read(145);

    // Run 2: abort with reset while SCLK1 is high inside READ.
    push(K_RELAY_P, 250);
    adc_en = 1'b1;
    start_pulse = 1'b1; cycles(3); start_pulse = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (SCLK1) break;
    end
    check("abort_reached_read", 64'(SCLK1), 64'd1);
    res = 1'b1;
    adc_en = 1'b0;
    @(posedge clk);
    #1;
    check("abort_sclk1", 64'(SCLK1), 64'h0);
    check("abort_relays", 64'({relayAp, relayAn, relayBp, relayBn}), 64'h0);
    check("abort_data_done", 64'(data_done), 64'h0);
    check("abort_sdinu_cse", 64'({SDINu, CSe}), 64'hF);
    cycles(3);
    res = 1'b0;
    cycles(2);

    // Run 3: full acquisition after the abort, three events, readout wraps into a second count word.
    start_run();
    cycles(300);
    repeat (3) event_pulse();
    wait_done("run3_done_seen");

    push(K_WORD, 3);
    for (int i = 0; i < 8; i++) push(K_WORD, 32'(i));
    push(K_WORD, 3);
    mcu_read(160);

    cycles(20);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/logger_acq_core.md
Name: logger_acq_core

Overview:
Acquisition core of the FPGA data logger. On `start_pulse` it:
- drives latching polarity relays,
- reads `N_SAMPLES` 16-bit words from a serial ADC (data-ready strobe plus bit-banged serial clock),
- counts external `pulse_in` events over the run,
- buffers the results and flags completion on `data_done`.

A microcontroller reads the buffer through an SPI-slave port. An ADC master clock `Clk_Out` is generated. The EEPROM SPI port is reserved.

Parameters:
- N_SAMPLES, 8, words captured per acquisition (power of 2, 2..16).
- SCLK_HALF, 4, `SCLK1` half-period in `clk` cycles (>=4).
- CLKOUT_DIV, 2, `Clk_Out` toggles every CLKOUT_DIV cycles (`clk`/4 at default).
- RELAY_CYC, 250, relay coil pulse width in `clk` cycles.

Ports:
- clk, in, 1, system clock (25 MHz nominal).
- res, in, 1, synchronous active-high reset.
- start_pulse, in, 1, start acquisition (sampled high while IDLE).
- data_done, out, 1, one-cycle pulse when run completes.
- pulse_in, in, 1, external event input.
- relayAp/relayAn/relayBp/relayBn, out, 1 each, relay coil drives.
- Clk_Out, out, 1, ADC master clock.
- SDOUTu, in, 1, MCU MOSI (ignored).
- SCLKu, in, 1, MCU SPI clock.
- CSu, in, 1, MCU chip select, active low.
- SDINu, out, 1, MCU MISO.
- nDRDY, in, 1, ADC data-ready; a rising edge marks a new word.
- SDIN1, in, 1, ADC serial data, MSB first.
- SCLK1, out, 1, ADC serial clock, idle low.
- SDOUTe, in, 1, EEPROM MISO (reserved).
- SDINe/SCLKe, out, 1, EEPROM MOSI/clock (reserved).
- CSe, out, 4, EEPROM chip selects, active low.

Behaviour:
- All asynchronous inputs pass through 2-FF synchronizers. Edge detection compares the 2nd and 3rd stages.
- Reset values:
  - all relays 0, `data_done` 0, `SCLK1` 0, `Clk_Out` 0, `SDINu` 0;
  - `CSe` 4'hF, `SCLKe` 0, `SDINe` 0;
  - buffer, pulse count and all counters 0;
  - FSM in IDLE.
- Reset mid-run aborts immediately to the reset values.
- `Clk_Out` is free-running.
- `CSe`, `SCLKe` and `SDINe` are held at their reset values permanently.
- FSM states: IDLE, RELAY_ON, WAIT_DRDY, READ, STORE, RELAY_OFF, DONE.
- IDLE: on `start_pulse`=1, clear the pulse counter and word index, then go to RELAY_ON. Any `start_pulse` outside IDLE is ignored.
- RELAY_ON: `relayAp` = `relayBp` = 1 for exactly RELAY_CYC cycles, then 0, then WAIT_DRDY.
- WAIT_DRDY: wait for a synchronized rising edge of `nDRDY`, then READ.
- READ: 16 `SCLK1` periods, each SCLK_HALF cycles low then SCLK_HALF cycles high.
  - Sample synced `SDIN1` on the last clk of each high phase.
  - Shift into the word MSB first; `SCLK1` ends low.
  - Then STORE.
- STORE: write the word to buffer[index] and increment index.
  - If index reaches N_SAMPLES, go to RELAY_OFF; else go to WAIT_DRDY.
- RELAY_OFF: `relayAn` = `relayBn` = 1 for RELAY_CYC cycles, then DONE.
- DONE: `data_done` = 1 for one cycle, then IDLE.
- The p and n coil of a pair are never high simultaneously.
- Pulse counter: 16-bit, increments on each synced rising edge of `pulse_in` while the FSM is in WAIT_DRDY, READ or STORE. It saturates at 16'hFFFF.
- MCU SPI-slave read port:
  - Bit stream order: pulse count word first, then buffer[0..N_SAMPLES-1], each MSB first, 16·(N_SAMPLES+1) bits.
  - On synced `CSu` falling edge: bit pointer = 0, `SDINu` = first bit.
  - On each synced `SCLKu` falling edge while `CSu` = 0: the pointer advances and `SDINu` presents the next bit.
  - Past the end the stream wraps to the count word.
  - `CSu` = 1: `SDINu` = 0.
  - Reading during a run returns live contents.

Decomposition:
- Package `logger_pkg`: FSM state enum, word width constant (16) and the buffer index width derived from N_SAMPLES.
- One natural sub-module: `adc_serial_rx`. It takes start, SDIN1 and SCLK_HALF, and returns SCLK1, the 16-bit word and a done strobe.

Test Plan:
- Reset: `res`=1 for 3 cycles -> `CSe`=4'hF; relays, `SCLK1`, `data_done` and `SDINu` all 0.
- Start and relay:
  - Stimulus: `start_pulse` for 3 cycles.
  - Response: `relayAp`=`relayBp`=1 for exactly 250 cycles, `relayAn`=`relayBn`=0.
  - A second `start_pulse` mid-run has no effect.
- ADC capture:
  - ADC model: `nDRDY` high 250 ns every 31.25 µs; a counter (0,1,2,...) is loaded on each `nDRDY` rising edge and shifted out on `SCLK1` falling edges.
  - Capture: 16 `SCLK1` pulses per `nDRDY`; buffer = 0,1,...,7.
  - Completion: relayAn/Bn pulse 250 cycles, then a single `data_done` pulse.
- Pulse count: 5 `pulse_in` pulses (200 ns high) during the run, plus 3 while IDLE -> count word = 5.
- MCU readout: `CSu` low, 144 `SCLKu` clocks (1 MHz) -> bitstream decodes to 5, 0,1,...,7. Clock 145 returns the MSB of the count word.
- Reset mid-READ: all outputs return to reset values the next cycle; a new start runs a full acquisition correctly.
